lc3_regfile_cc: RTL

//   LC-3 general-purpose register file (R0-R7) plus condition-code (NZP) and BEN latches.

---
 rtl/lc3_regfile_cc_if.sv | 29 ++
 rtl/lc3_regfile_cc.sv | 69 ++++++
 2 files changed

// File: rtl/lc3_regfile_cc_if.sv
// Bus bundle between the LC-3 datapath and its register file / condition-code block.
// The master drives the selects, strobes and writeback value. The slave returns the operands, NZP and BEN.
interface lc3_regfile_cc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] bus_in;
    logic              ld_reg;
    logic [ADDR_W-1:0] dr;
    logic [ADDR_W-1:0] sr1;
    logic [ADDR_W-1:0] sr2;
    logic [DATA_W-1:0] Ra;
    logic [DATA_W-1:0] Rb;
    logic              ld_cc;
    logic [2:0]        nzp;
    logic              ld_ben;
    logic [2:0]        ir_nzp;
    logic              ben;

    modport master (
        output bus_in, ld_reg, dr, sr1, sr2, ld_cc, ld_ben, ir_nzp,
        input  Ra, Rb, nzp, ben
    );

    modport slave (
        input  bus_in, ld_reg, dr, sr1, sr2, ld_cc, ld_ben, ir_nzp,
        output Ra, Rb, nzp, ben
    );
endinterface

// File: rtl/lc3_regfile_cc.sv
// LC-3 register file R0-R7 with the NZP condition-code latch and the BEN latch.
// Define REGFILE_BYPASS_EN to make a same-cycle write visible on Ra/Rb (write-through).
module lc3_regfile_cc #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    lc3_regfile_cc_if.slave   rf
);

    generate
        if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
            $error("lc3_regfile_cc: NUM_REGS must equal 2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        nzp_q;
    logic [2:0]        nzp_next;
    logic              ben_q;

    // The bus value is signed: the sign bit gives N, zero gives Z, and anything else gives P.
    always_comb begin
        nzp_next = 3'b001;
        if (rf.bus_in[DATA_W-1]) begin
            nzp_next = 3'b100;
        end else if (rf.bus_in == '0) begin
            nzp_next = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is cleared explicitly because the architecture promises R0-R7 == 0
            // after reset. This rules out an inferred RAM macro, which is acceptable at only 8 entries.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (rf.ld_reg) begin
                regs[rf.dr] <= rf.bus_in;
            end
            if (rf.ld_cc) begin
                nzp_q <= nzp_next;
            end
            // NOTE: with non-blocking assignments this reads the nzp held before the edge,
            // so a BR decision made together with ld_cc still sees the older condition code.
            if (rf.ld_ben) begin
                ben_q <= |(rf.ir_nzp & nzp_q);
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rf.Ra = (rf.ld_reg && (rf.dr == rf.sr1)) ? rf.bus_in : regs[rf.sr1];
    assign rf.Rb = (rf.ld_reg && (rf.dr == rf.sr2)) ? rf.bus_in : regs[rf.sr2];
`else
    assign rf.Ra = regs[rf.sr1];
    assign rf.Rb = regs[rf.sr2];
`endif

    assign rf.nzp = nzp_q;
    assign rf.ben = ben_q;

endmodule
